// File: rtl/icache_fetch.sv
// ---------------------------------------------------------------------------
// icache_fetch
//   Direct-mapped, read-only instruction cache that sits between the PC
//   register and the IF/ID pipeline register. Lookups are combinational, so
//   a hit returns the instruction in the same cycle. A miss raises stall_o
//   and a two-state FSM (IDLE / REFILL) fetches one whole line from the
//   memory port, counting beats in ascending word order.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   fetch_en_i      : fetch requested this cycle
//   PC_i            : fetch address (bits [1:0] ignored)
//   invalidate_i    : clear every valid bit (fence.i)
//   instr_o, hit_o  : instruction, qualified by hit_o
//   stall_o         : PC and IF/ID must hold
//   mem_req_o       : refill request, high for the whole REFILL state
//   mem_addr_o      : line-aligned refill address while mem_req_o is high
//   mem_rvalid_i    : one refill beat is present on mem_rdata_i
//   mem_rdata_i     : refill word
//
// Memory handshake: mem_req_o/mem_addr_o are held constant while refilling;
// every cycle in REFILL with mem_rvalid_i high consumes exactly one word.
// There is no back-pressure toward memory. mem_rvalid_i is ignored in IDLE.
// ---------------------------------------------------------------------------
module icache_fetch #(
    parameter int DATA_WIDTH  = 32,
    parameter int SETS        = 64,
    parameter int BLOCK_WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_en_i,
    input  logic [DATA_WIDTH-1:0] PC_i,
    input  logic                  invalidate_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic                  hit_o,
    output logic                  stall_o,
    output logic                  mem_req_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam int WB = $clog2(BLOCK_WORDS);
    localparam int OB = WB + 2;
    localparam int IB = $clog2(SETS);
    localparam int TW = DATA_WIDTH - OB - IB;

    typedef enum logic {IDLE, REFILL} state_t;

    state_t                state;
    state_t                state_nx;
    logic [WB-1:0]         beat;
    logic [DATA_WIDTH-1:0] miss_addr;
    logic                  inv_pending;
    logic [SETS-1:0]       valid;

    logic [TW-1:0]         tag_mem  [SETS];
    logic [DATA_WIDTH-1:0] data_mem [SETS][BLOCK_WORDS];

    logic [WB-1:0]         pc_word;
    logic [IB-1:0]         pc_index;
    logic [TW-1:0]         pc_tag;
    logic [IB-1:0]         miss_index;
    logic [TW-1:0]         miss_tag;
    logic                  lookup_hit;
    logic                  beat_last;
    logic                  refill_beat;
    logic                  refill_done;
    logic                  pc_lsb_unused;

    assign pc_word       = PC_i[OB-1:2];
    assign pc_index      = PC_i[OB+IB-1:OB];
    assign pc_tag        = PC_i[DATA_WIDTH-1:OB+IB];
    assign pc_lsb_unused = ^PC_i[1:0];

    assign miss_index = miss_addr[OB+IB-1:OB];
    assign miss_tag   = miss_addr[DATA_WIDTH-1:OB+IB];

    assign lookup_hit  = fetch_en_i & valid[pc_index] & (tag_mem[pc_index] == pc_tag);
    assign beat_last   = (beat == WB'(BLOCK_WORDS - 1));
    assign refill_beat = (state == REFILL) & mem_rvalid_i;
    assign refill_done = refill_beat & beat_last;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (fetch_en_i && !lookup_hit) state_nx = REFILL;
            REFILL:  if (refill_done)               state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        hit_o      = 1'b0;
        instr_o    = '0;
        stall_o    = 1'b0;
        mem_req_o  = 1'b0;
        mem_addr_o = '0;
        case (state)
            IDLE: begin
                hit_o   = lookup_hit;
                instr_o = lookup_hit ? data_mem[pc_index][pc_word] : '0;
                stall_o = fetch_en_i & ~lookup_hit;
            end
            REFILL: begin
                mem_req_o  = 1'b1;
                mem_addr_o = miss_addr;
                stall_o    = 1'b1;
            end
            default: ;
        endcase
    end

    // Control datapath: beat counter, miss address, valid bits
    always_ff @(posedge clk) begin
        if (rst) begin
            beat        <= '0;
            miss_addr   <= '0;
            inv_pending <= 1'b0;
            valid       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // The lookup this cycle already used the old valid bits.
                    if (invalidate_i) valid <= '0;
                    if (fetch_en_i && !lookup_hit)
                        miss_addr <= {PC_i[DATA_WIDTH-1:OB], {OB{1'b0}}};
                end
                REFILL: begin
                    if (invalidate_i) inv_pending <= 1'b1;
                    if (refill_beat) beat <= beat + WB'(1);
                    if (refill_done) begin
                        beat        <= '0;
                        inv_pending <= 1'b0;
                        // A fence.i seen during the refill (including on the
                        // final beat) also drops the line just filled.
                        if (inv_pending || invalidate_i) valid <= '0;
                        else                             valid[miss_index] <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Arrays are not reset; a beat arriving with rst high is dropped.
    always_ff @(posedge clk) begin
        if (!rst && refill_beat) data_mem[miss_index][beat] <= mem_rdata_i;
        if (!rst && refill_done) tag_mem[miss_index] <= miss_tag;
    end

endmodule

// File: tb/tb_icache_fetch.sv
module tb_icache_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en_i;
  logic [31:0] PC_i;
  logic        invalidate_i;
  logic [31:0] instr_o;
  logic        hit_o;
  logic        stall_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];   // expected instr_o for each hit_o cycle
  logic [31:0] req_q[$];   // expected mem_addr_o for each refill request
  logic [31:0] cur_req;
  logic        prev_req;

  icache_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_en_i   (fetch_en_i),
    .PC_i         (PC_i),
    .invalidate_i (invalidate_i),
    .instr_o      (instr_o),
    .hit_o        (hit_o),
    .stall_o      (stall_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // drivers: inputs change 1 time unit after posedge, then settle
  task automatic drive(input logic f, input logic [31:0] pc, input logic inv,
                       input logic rv, input logic [31:0] rd);
    fetch_en_i   = f;
    PC_i         = pc;
    invalidate_i = inv;
    mem_rvalid_i = rv;
    mem_rdata_i  = rd;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Miss cycle in IDLE: expect a stall and queue the refill request.
  task automatic miss(input logic [31:0] pc, input string name);
    drive(1'b1, pc, 1'b0, 1'b0, 32'h0);
    chk({name, "_miss_hit"},   {31'b0, hit_o},     32'd0);
    chk({name, "_miss_stall"}, {31'b0, stall_o},   32'd1);
    chk({name, "_miss_req"},   {31'b0, mem_req_o}, 32'd0);
    req_q.push_back({pc[31:4], 4'h0});
    tick();
  endtask

  // One REFILL cycle; rv selects a beat or a wait cycle.
  task automatic refill_cyc(input logic [31:0] pc, input logic inv, input logic rv,
                            input logic [31:0] rd, input string name);
    drive(1'b1, pc, inv, rv, rd);
    chk({name, "_rf_stall"}, {31'b0, stall_o},   32'd1);
    chk({name, "_rf_req"},   {31'b0, mem_req_o}, 32'd1);
    chk({name, "_rf_addr"},  mem_addr_o,         {pc[31:4], 4'h0});
    tick();
  endtask

  task automatic hit(input logic [31:0] pc, input logic inv, input logic [31:0] instr,
                     input string name);
    drive(1'b1, pc, inv, 1'b0, 32'h0);
    exp_q.push_back(instr);
    chk({name, "_hit"},   {31'b0, hit_o},     32'd1);
    chk({name, "_stall"}, {31'b0, stall_o},   32'd0);
    chk({name, "_req"},   {31'b0, mem_req_o}, 32'd0);
    tick();
  endtask

  // scoreboard monitor: samples on the falling edge
  initial begin
    prev_req = 1'b0;
    cur_req  = 32'h0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        if (hit_o) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL mon_unexpected_hit actual=%h required=no_hit", instr_o);
          end else begin
            chk("mon_instr", instr_o, exp_q.pop_front());
          end
        end else begin
          chk("mon_instr_zero", instr_o, 32'h0);
        end
        if (mem_req_o) begin
          if (!prev_req) begin
            if (req_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL mon_unexpected_req actual=%h required=no_req", mem_addr_o);
            end else begin
              cur_req = req_q.pop_front();
            end
          end
          chk("mon_req_addr", mem_addr_o, cur_req);
        end else begin
          chk("mon_addr_idle", mem_addr_o, 32'h0);
        end
      end
      prev_req = mem_req_o;
    end
  end

  // stimulus
  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    rst = 1'b0;

    // reset state: nothing valid, idle, no request
    drive(1'b0, 32'hBFC0_0000, 1'b0, 1'b0, 32'h0);
    chk("rst_hit",   {31'b0, hit_o},     32'd0);
    chk("rst_stall", {31'b0, stall_o},   32'd0);
    chk("rst_req",   {31'b0, mem_req_o}, 32'd0);
    chk("rst_instr", instr_o,            32'h0);

    // cold miss, back-to-back beats: 1 miss + 4 refill stall cycles
    miss(32'hBFC0_0000, "cold");
    refill_cyc(32'hBFC0_0000, 1'b0, 1'b1, 32'h11, "cold0");
    refill_cyc(32'hBFC0_0000, 1'b0, 1'b1, 32'h22, "cold1");
    refill_cyc(32'hBFC0_0000, 1'b0, 1'b1, 32'h33, "cold2");
    refill_cyc(32'hBFC0_0000, 1'b0, 1'b1, 32'h44, "cold3");
    hit(32'hBFC0_0000, 1'b0, 32'h11, "cold_after");

    // sequential hits
    hit(32'hBFC0_0004, 1'b0, 32'h22, "seq1");
    hit(32'hBFC0_0008, 1'b0, 32'h33, "seq2");
    hit(32'hBFC0_000C, 1'b0, 32'h44, "seq3");

    // conflict miss with gapped beats; junk data on wait cycles must be dropped
    miss(32'hBFC0_0400, "conf");
    for (int i = 0; i < 4; i++) begin
      refill_cyc(32'hBFC0_0400, 1'b0, 1'b0, 32'hDEAD_BEEF, "conf_gap");
      refill_cyc(32'hBFC0_0400, 1'b0, 1'b1, 32'hA1 + i, "conf_beat");
    end
    hit(32'hBFC0_0400, 1'b0, 32'hA1, "conf_w0");
    hit(32'hBFC0_0404, 1'b0, 32'hA2, "conf_w1");
    hit(32'hBFC0_0408, 1'b0, 32'hA3, "conf_w2");
    hit(32'hBFC0_040C, 1'b0, 32'hA4, "conf_w3");

    // the evicted line now misses; refill it back
    miss(32'hBFC0_0000, "evict");
    for (int i = 0; i < 4; i++)
      refill_cyc(32'hBFC0_0000, 1'b0, 1'b1, 32'h11 * (i + 1), "evict_rf");

    // invalidate in IDLE: same-cycle hit still uses old valid bits
    hit(32'hBFC0_0000, 1'b1, 32'h11, "inv_same");
    miss(32'hBFC0_0000, "inv_next");

    // invalidate pulsed on beat 2 of that refill
    refill_cyc(32'hBFC0_0000, 1'b0, 1'b1, 32'h51, "invrf0");
    refill_cyc(32'hBFC0_0000, 1'b0, 1'b1, 32'h52, "invrf1");
    refill_cyc(32'hBFC0_0000, 1'b1, 1'b1, 32'h53, "invrf2");
    refill_cyc(32'hBFC0_0000, 1'b0, 1'b1, 32'h54, "invrf3");
    miss(32'hBFC0_0000, "invrf_after");

    // reset after beat 1 of this refill
    refill_cyc(32'hBFC0_0000, 1'b0, 1'b1, 32'h61, "rstrf0");
    refill_cyc(32'hBFC0_0000, 1'b0, 1'b1, 32'h62, "rstrf1");
    rst = 1'b1;
    drive(1'b1, 32'hBFC0_0000, 1'b0, 1'b1, 32'h63);
    tick();
    rst = 1'b0;
    // leftover beats arrive while idle and must be ignored
    drive(1'b0, 32'hBFC0_0000, 1'b0, 1'b1, 32'h64);
    chk("rstrf_req",   {31'b0, mem_req_o}, 32'd0);
    chk("rstrf_hit",   {31'b0, hit_o},     32'd0);
    chk("rstrf_stall", {31'b0, stall_o},   32'd0);
    tick();
    drive(1'b0, 32'hBFC0_0000, 1'b0, 1'b1, 32'h65);
    chk("rstrf_req2",  {31'b0, mem_req_o}, 32'd0);
    tick();

    // fresh miss must refill from beat 0
    miss(32'hBFC0_0000, "fresh");
    for (int i = 0; i < 4; i++)
      refill_cyc(32'hBFC0_0000, 1'b0, 1'b1, 32'h71 + i, "fresh_rf");
    hit(32'hBFC0_0000, 1'b0, 32'h71, "fresh_w0");
    hit(32'hBFC0_0004, 1'b0, 32'h72, "fresh_w1");
    hit(32'hBFC0_0008, 1'b0, 32'h73, "fresh_w2");
    hit(32'hBFC0_000C, 1'b0, 32'h74, "fresh_w3");

    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();

    chk("final_exp_q_empty", exp_q.size(), 32'd0);
    chk("final_req_q_empty", req_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_fetch.md
Name: icache_fetch

Overview:
- Direct-mapped, read-only instruction cache between pc_module and the IF/ID pipeline register.
- Takes the fetch PC each cycle and returns the instruction on a hit in the same cycle.
- On a miss it asserts stall_o, which drives pc_module's en through an inverter, and refills one line from the memory port with a beat-counting FSM.

Parameters:
- DATA_WIDTH, 32: instruction, address and memory word width.
- SETS, 64: number of lines; power of two.
- BLOCK_WORDS, 4: 32-bit words per line; power of two, at least 2.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset.
- fetch_en_i, input, 1: a fetch is requested this cycle.
- PC_i, input, DATA_WIDTH: fetch address. Bits [1:0] are ignored.
- invalidate_i, input, 1: invalidate all lines (fence.i).
- instr_o, output, DATA_WIDTH: instruction. Valid only when hit_o is high.
- hit_o, output, 1: instr_o is valid this cycle.
- stall_o, output, 1: PC and IF/ID must hold.
- mem_req_o, output, 1: line-refill request.
- mem_addr_o, output, DATA_WIDTH: line-aligned refill address.
- mem_rvalid_i, input, 1: one refill beat is present on mem_rdata_i.
- mem_rdata_i, input, DATA_WIDTH: refill word. Beats arrive in ascending word order.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on rst.
- Address split. OB = log2(BLOCK_WORDS)+2 and IB = log2(SETS).
  - word = PC_i[OB-1:2]
  - index = PC_i[OB+IB-1:OB]
  - tag = PC_i[31:OB+IB]
  - With defaults: word [3:2], index [9:4], tag [31:10].
- Storage:
  - Data array is SETS x BLOCK_WORDS words.
  - Tag array is SETS entries.
  - valid is SETS flops.
  - Read is asynchronous (combinational).
- States: IDLE, REFILL.
- IDLE:
  - hit_o = fetch_en_i & valid[index] & (tag_array[index] == tag).
  - instr_o = data[index][word] on a hit, else 0.
  - stall_o = fetch_en_i & ~hit_o.
  - On a miss, latch the line address {tag, index, OB zeros} into miss_addr and go to REFILL at the next edge.
  - With fetch_en_i low: hit_o = 0, stall_o = 0, no state change.
- REFILL:
  - mem_req_o = 1 and mem_addr_o = miss_addr, both held constant for the whole state.
  - stall_o = 1, hit_o = 0, instr_o = 0.
  - PC_i is not sampled.
  - Each cycle with mem_rvalid_i high, mem_rdata_i is written to data[miss index][beat], then beat increments.
  - Cycles without rvalid insert wait cycles and write nothing.
  - On the beat where beat == BLOCK_WORDS-1: write tag, set valid, clear beat, go to IDLE.
  - The lookup in the following IDLE cycle hits.
- Miss latency with back-to-back beats: miss cycle + BLOCK_WORDS REFILL cycles, then hit. With defaults, stall_o is high for 5 cycles.
- Outside REFILL: mem_req_o = 0 and mem_addr_o = 0. mem_rvalid_i is ignored in IDLE.
- Replacement: a refill overwrites the indexed line unconditionally (conflict eviction).
- invalidate_i:
  - In IDLE: all valid bits clear at the next edge. A lookup in the same cycle still uses the pre-clear valid bits.
  - In REFILL: latched as pending. On refill completion all valid bits are cleared, including the line just filled. Next cycle is a miss.
- Reset (any state, including mid-refill) takes effect at the next edge:
  - state = IDLE, all valid = 0, beat = 0, miss_addr = 0, pending invalidate = 0.
  - Outputs after reset: mem_req_o = 0, mem_addr_o = 0, hit_o = 0, instr_o = 0. stall_o = fetch_en_i, since every lookup misses.
  - Data and tag arrays are not reset.
  - Beats from an aborted refill are dropped.
- No speculative fetch, no critical-word-first, and at most one outstanding refill.

Test Plan:
- Cold miss: rst for 2 cycles, then PC_i = 0xBFC00000 with fetch_en_i = 1. Memory returns 0x11,0x22,0x33,0x44 on consecutive cycles. Required:
  - mem_req_o high for 4 cycles with mem_addr_o = 0xBFC00000.
  - stall_o high for 5 cycles.
  - Next cycle: hit_o = 1, instr_o = 0x11.
- Sequential hits: after the cold miss, PC_i = 0xBFC00004, 0xBFC00008, 0xBFC0000C on consecutive cycles. Required: hit_o = 1 each cycle, instr_o = 0x22, 0x33, 0x44, stall_o = 0, mem_req_o = 0.
- Conflict and waits: PC_i = 0xBFC00400 (same index, tag differs) with gapped beats (rvalid on every other cycle). Required:
  - mem_addr_o = 0xBFC00400 held through all gaps.
  - Exactly 4 words written.
  - Afterwards 0xBFC00400 hits and 0xBFC00000 misses.
- Invalidate: with a hit line resident, pulse invalidate_i in IDLE. Required: same-cycle hit_o = 1; next cycle same PC gives hit_o = 0 and a refill starts.
- Invalidate during refill: pulse invalidate_i on beat 2 of a refill. Required: refill completes, then the next lookup of that PC misses again.
- Reset mid-refill: assert rst after beat 1. Required:
  - Next cycle: state IDLE, mem_req_o = 0, no hits.
  - Remaining rvalid beats are ignored.
  - A fresh miss refills from beat 0.
